fu_mul_pipe: RTL and testbench



---
 rtl/fu_mul_pipe.sv | 131 +++++++++++++
 tb/tb_fu_mul_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M multiply unit shared by NCH issue channels. Fixed-priority
// arbitration admits one op per cycle; each op carries its channel ID to the finish.
module fu_mul_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NCH     = 2,
    parameter int unsigned LATENCY = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [2*NCH-1:0]     op,
    input  logic [XLEN*NCH-1:0]  A,
    input  logic [XLEN*NCH-1:0]  B,
    output logic [NCH-1:0]       accept,
    output logic [NCH-1:0]       busy,
    output logic [XLEN*NCH-1:0]  res,
    output logic [NCH-1:0]       finish
);

    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned NST = LATENCY - 1;

    logic [NST-1:0]        r_vld;
    logic [NST-1:0]        r_hi;
    logic [CW-1:0]         r_ch [NST];
    logic [2*XLEN-1:0]     r_p  [NST];
    logic [NCH-1:0][XLEN-1:0] r_res;
    logic [NCH-1:0]        r_fin;

    logic [NCH-1:0]        w_busy;
    logic [NCH-1:0]        w_elig;
    logic [NCH-1:0]        w_acc;
    logic                  w_any;
    logic [CW-1:0]         w_sel;
    logic [1:0]            w_op;
    logic [XLEN-1:0]       w_a;
    logic [XLEN-1:0]       w_b;
    logic                  w_sa;
    logic                  w_sb;
    logic                  w_hi;
    logic [2*XLEN-1:0]     w_ea;
    logic [2*XLEN-1:0]     w_eb;
    logic [2*XLEN-1:0]     w_prod;

    // A channel is busy while its op sits in any pipeline stage; the finish
    // cycle is held in the result register, so the channel is free again there.
    always_comb begin
        w_busy = '0;
        for (int unsigned k = 0; k < NST; k++) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (r_vld[k] && (r_ch[k] == CW'(i))) begin
                    w_busy[i] = 1'b1;
                end
            end
        end
    end

    assign w_elig = en & ~w_busy;

    always_comb begin
        w_acc = '0;
        w_any = 1'b0;
        w_sel = '0;
        w_op  = '0;
        w_a   = '0;
        w_b   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_elig[i] && !w_any) begin
                w_acc[i] = 1'b1;
                w_any    = 1'b1;
                w_sel    = CW'(i);
                w_op     = op[2*i +: 2];
                w_a      = A[XLEN*i +: XLEN];
                w_b      = B[XLEN*i +: XLEN];
            end
        end
    end

    // Extending to 2*XLEN with the mode's sign bit and multiplying modulo
    // 2^(2*XLEN) yields the same low 2*XLEN bits as the signed (XLEN+1)-bit product.
    assign w_sa   = (w_op != 2'b11) & w_a[XLEN-1];
    assign w_sb   = (w_op == 2'b01) & w_b[XLEN-1];
    assign w_hi   = (w_op != 2'b00);
    assign w_ea   = {{XLEN{w_sa}}, w_a};
    assign w_eb   = {{XLEN{w_sb}}, w_b};
    assign w_prod = w_ea * w_eb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_hi  <= '0;
            for (int unsigned k = 0; k < NST; k++) begin
                r_ch[k] <= '0;
                r_p[k]  <= '0;
            end
        end else begin
            r_vld[0] <= w_any;
            r_hi[0]  <= w_hi;
            r_ch[0]  <= w_sel;
            r_p[0]   <= w_prod;
            for (int unsigned k = 1; k < NST; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_hi[k]  <= r_hi[k-1];
                r_ch[k]  <= r_ch[k-1];
                r_p[k]   <= r_p[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_fin <= '0;
        end else begin
            r_fin <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (r_vld[NST-1] && (r_ch[NST-1] == CW'(i))) begin
                    r_fin[i] <= 1'b1;
                    r_res[i] <= r_hi[NST-1] ? r_p[NST-1][2*XLEN-1:XLEN]
                                            : r_p[NST-1][XLEN-1:0];
                end
            end
        end
    end

    assign accept = w_acc;
    assign busy   = w_busy;
    assign res    = r_res;
    assign finish = r_fin;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Directed bench for fu_mul_pipe: default build (NCH=2, LATENCY=7) and a
// NCH=4, LATENCY=3 build sharing one clock and reset.
module tb_fu_mul_pipe;

    logic         clk;
    logic         rst;

    logic [1:0]   en0;
    logic [3:0]   op0;
    logic [63:0]  a0;
    logic [63:0]  b0;
    logic [1:0]   acc0;
    logic [1:0]   busy0;
    logic [63:0]  res0;
    logic [1:0]   fin0;

    logic [3:0]   en1;
    logic [7:0]   op1;
    logic [127:0] a1;
    logic [127:0] b1;
    logic [3:0]   acc1;
    logic [3:0]   busy1;
    logic [127:0] res1;
    logic [3:0]   fin1;

    int n_err;
    int n_chk;

    fu_mul_pipe #(.XLEN(32), .NCH(2), .LATENCY(7)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .op(op0), .A(a0), .B(b0),
        .accept(acc0), .busy(busy0), .res(res0), .finish(fin0)
    );

    fu_mul_pipe #(.XLEN(32), .NCH(4), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .op(op1), .A(a1), .B(b1),
        .accept(acc1), .busy(busy1), .res(res1), .finish(fin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op on dut0 channel 0 in the current cycle and follows it to finish;
    // returns positioned in the finish cycle.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        en0[0]    = 1'b1;
        op0[1:0]  = m;
        a0[31:0]  = a;
        b0[31:0]  = b;
        #1;
        chk({tag, " accept"}, 64'(acc0), 64'(2'b01));
        for (int k = 1; k < 7; k++) begin
            tick();
            en0[0] = 1'b0;
            #1;
            chk({tag, " busy"}, 64'(busy0[0]), 64'(1'b1));
            chk({tag, " nofin"}, 64'(fin0), 64'(2'b00));
        end
        tick();
        #1;
        chk({tag, " finish"}, 64'(fin0), 64'(2'b01));
        chk({tag, " idle"}, 64'(busy0[0]), 64'(1'b0));
        chk({tag, " res"}, 64'(res0[31:0]), 64'(exp));
    endtask

    logic [31:0] e6 [4];
    logic [3:0]  exp_busy;

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        en0 = '0; op0 = '0; a0 = '0; b0 = '0;
        en1 = '0; op1 = '0; a1 = '0; b1 = '0;
        #2;
        chk("rst busy0", 64'(busy0), 64'(0));
        chk("rst fin0", 64'(fin0), 64'(0));
        chk("rst res0", res0, 64'(0));
        chk("rst res1", res1[63:0], 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic MUL with latency and hold check.
        run_op("t1 mul", 2'b00, 32'h7, 32'h6, 32'h0000002A);
        tick();
        #1;
        chk("t1 fin drop", 64'(fin0), 64'(0));
        chk("t1 res hold", 64'(res0[31:0]), 64'h2A);

        // Mode sweep, each issued back-to-back in the previous finish cycle.
        tick();
        run_op("t2 mul",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("t2 mulh",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("t2 mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("t2 mulhu",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("t2 mulh min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("t2 mulhsu neg", 2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        run_op("t2 mulhu big", 2'b11, 32'h80000000, 32'h00000004, 32'h00000002);
        run_op("t2 mul lo", 2'b00, 32'h12345678, 32'h00000010, 32'h23456780);
        run_op("t2 mulh mixed", 2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

        // Two channels requesting together.
        tick();
        en0 = 2'b11;
        op0 = '0;
        a0  = {32'd4, 32'd2};
        b0  = {32'd5, 32'd3};
        #1;
        chk("t3 acc c", 64'(acc0), 64'(2'b01));
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) en0[0] = 1'b0;
            if (k == 2) en0[1] = 1'b0;
            #1;
            chk("t3 acc", 64'(acc0), 64'((k == 1) ? 2'b10 : 2'b00));
            chk("t3 fin", 64'(fin0), 64'((k == 7) ? 2'b01 : (k == 8) ? 2'b10 : 2'b00));
            if (k == 7) begin
                chk("t3 res0", 64'(res0[31:0]), 64'd6);
                chk("t3 res1 idle", 64'(res0[63:32]), 64'd0);
            end
            if (k == 8) begin
                chk("t3 res1", 64'(res0[63:32]), 64'd20);
                chk("t3 res0 hold", 64'(res0[31:0]), 64'd6);
            end
        end

        // Continuous request on ch0: re-accept only in the finish cycle.
        tick();
        op0 = '0;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) tick();
            a0[31:0] = 32'(k + 1);
            b0[31:0] = 32'd3;
            en0[0]   = (k != 14);
            #1;
            chk("t4 acc", 64'(acc0[0]), 64'((k == 0) || (k == 7)));
            chk("t4 fin", 64'(fin0[0]), 64'((k == 7) || (k == 14)));
            if (k == 7)  chk("t4 res1st", 64'(res0[31:0]), 64'd3);
            if (k == 14) chk("t4 res2nd", 64'(res0[31:0]), 64'd24);
        end

        // Asynchronous reset mid-operation.
        tick();
        en0[0] = 1'b1; op0[1:0] = 2'b00; a0[31:0] = 32'd5; b0[31:0] = 32'd5;
        #1;
        chk("t5 acc", 64'(acc0), 64'(2'b01));
        for (int k = 1; k <= 3; k++) begin
            tick();
            en0[0] = 1'b0;
            #1;
        end
        chk("t5 busy pre", 64'(busy0[0]), 64'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        chk("t5 rst busy", 64'(busy0), 64'(0));
        chk("t5 rst fin", 64'(fin0), 64'(0));
        chk("t5 rst res", res0, 64'(0));
        tick();
        rst = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            if (k > 4) tick();
            #1;
            chk("t5 no fin", 64'(fin0), 64'(0));
            chk("t5 no busy", 64'(busy0), 64'(0));
        end
        tick();
        run_op("t5 after", 2'b00, 32'd9, 32'd9, 32'h51);

        // Four channels, LATENCY=3.
        tick();
        a1 = {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1};
        b1 = {32'hFFFFFFFF, 32'd7, 32'd7, 32'd7};
        op1 = {2'b11, 2'b00, 2'b00, 2'b00};
        e6[0] = 32'd7; e6[1] = 32'd14; e6[2] = 32'd21; e6[3] = 32'hFFFFFFFE;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            en1 = (k < 4) ? (4'b1111 << k) : 4'b0000;
            #1;
            exp_busy = '0;
            for (int j = 0; j < 4; j++) begin
                if (j >= k - 2 && j <= k - 1) exp_busy[j] = 1'b1;
            end
            chk("t6 acc", 64'(acc1), 64'((k < 4) ? (4'b0001 << k) : 4'b0000));
            chk("t6 fin", 64'(fin1), 64'((k >= 3) ? (4'b0001 << (k - 3)) : 4'b0000));
            chk("t6 busy", 64'(busy1), 64'(exp_busy));
            if (k >= 3) chk("t6 res", 64'(res1[32*(k-3) +: 32]), 64'(e6[k-3]));
        end
        for (int j = 0; j < 4; j++) begin
            chk("t6 res final", 64'(res1[32*j +: 32]), 64'(e6[j]));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
